// File: rtl/ssd_scan_controller.sv
// rtl/ssd_scan_controller.sv - multiplexed 7-segment scan with guard blanking, PWM brightness and double-buffered frames
module ssd_scan_controller #(
    parameter int N_DIGITS    = 8,
    parameter int CLK_HZ      = 100_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter int GUARD_TICKS = 500,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*N_DIGITS-1:0]   wr_data,
    input  logic [N_DIGITS-1:0]     wr_mask,
    input  logic [N_DIGITS-1:0]     wr_dp,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);
    localparam int DIGIT_TICKS = CLK_HZ / (REFRESH_HZ * N_DIGITS);
    localparam int ON_TICKS    = DIGIT_TICKS - GUARD_TICKS;
    localparam int TW          = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int IW          = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int LW          = $clog2(ON_TICKS) + BRIGHT_W + 1;

    logic [TW-1:0]           t;
    logic [IW-1:0]           idx;
    logic [4*N_DIGITS-1:0]   act_data;
    logic [N_DIGITS-1:0]     act_mask;
    logic [N_DIGITS-1:0]     act_dp;
    logic [4*N_DIGITS-1:0]   pend_data;
    logic [N_DIGITS-1:0]     pend_mask;
    logic [N_DIGITS-1:0]     pend_dp;
    logic                    pend_full;
    logic [BRIGHT_W-1:0]     bright_q;

    logic          last_tick;
    logic          boundary;
    logic          frame_flag;
    logic          accept;
    logic [LW-1:0] lit_product;
    logic [LW-1:0] lit_ticks;
    logic [31:0]   t_ext;
    logic [31:0]   lit_ext;
    logic          lit;
    logic [3:0]    nibble;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0000011;
            4'hC:    decode = 7'b1000110;
            4'hD:    decode = 7'b0100001;
            4'hE:    decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign last_tick   = (t == TW'(DIGIT_TICKS - 1));
    assign boundary    = last_tick && (idx == IW'(N_DIGITS - 1));
    assign frame_flag  = (t == '0) && (idx == '0);
    assign wr_ready    = ~pend_full;
    assign accept      = wr_valid && ~pend_full;
    assign lit_product = (LW'(bright_q) + LW'(1)) * LW'(ON_TICKS);
    assign lit_ticks   = lit_product >> BRIGHT_W;
    assign t_ext       = 32'(t);
    assign lit_ext     = 32'(lit_ticks);
    assign nibble      = act_data[{idx, 2'b00} +: 4];
    assign lit         = act_mask[idx] && (t_ext >= GUARD_TICKS) && (t_ext < GUARD_TICKS + lit_ext);

    // Slot tick and digit index counters; index wraps at the end of the last slot
    always_ff @(posedge clk) begin
        if (!rstn) begin
            t   <= '0;
            idx <= '0;
        end else if (last_tick) begin
            t   <= '0;
            idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            t <= t + 1'b1;
        end
    end

    // Pending/active buffers: swap only at the frame boundary so a frame is never torn
    always_ff @(posedge clk) begin
        if (!rstn) begin
            act_data  <= '0;
            act_mask  <= '1;
            act_dp    <= '0;
            pend_data <= '0;
            pend_mask <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
            bright_q  <= '1;
        end else begin
            if (boundary && pend_full) begin
                act_data  <= pend_data;
                act_mask  <= pend_mask;
                act_dp    <= pend_dp;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_data <= wr_data;
                pend_mask <= wr_mask;
                pend_dp   <= wr_dp;
                pend_full <= 1'b1;
            end
            if (boundary) begin
                bright_q <= brightness;
            end
        end
    end

    // Registered display drive, one clock behind the (idx, t) state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_flag;
            if (lit) begin
                an  <= ~(N_DIGITS'(1) << idx);
                seg <= decode(nibble);
                dp  <= ~act_dp[idx];
            end else begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb/tb_ssd_scan_controller.sv - randomized model-checked bench for ssd_scan_controller
module tb_ssd_scan_controller;
    localparam int N  = 8;
    localparam int G  = 2;
    localparam int DT = 10;
    localparam int ON = 8;
    localparam int FT = N * DT;
    localparam int BW = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_data;
    logic [7:0]   wr_mask;
    logic [7:0]   wr_dp;
    logic [3:0]   brightness;
    logic [7:0]   an;
    logic [6:0]   seg;
    logic         dp;
    logic         frame_start;

    int checks   = 0;
    int failures = 0;

    ssd_scan_controller #(
        .N_DIGITS(8), .CLK_HZ(800), .REFRESH_HZ(10), .GUARD_TICKS(2), .BRIGHT_W(4)
    ) dut (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_dp(wr_dp), .brightness(brightness),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // behavioural model state
    bit          m_valid = 0;
    int          m_pos;
    int          out_pos = -1;
    int          m_idx, m_t, lit_n, m_bright;
    bit          on_win;
    logic [31:0] m_act_data, m_pend_data;
    logic [7:0]  m_act_mask, m_act_dp, m_pend_mask, m_pend_dp;
    bit          m_pend_full;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs, e_ready;
    bit          e_skip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is FT ticks; each tick's position decides the digit and phase
    always begin
        @(posedge clk);
        if (!rstn) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_skip = 0;
            m_pos = 0; out_pos = -1;
            m_act_data = 0; m_act_mask = 8'hFF; m_act_dp = 0;
            m_pend_full = 0; m_bright = 15; m_valid = 1;
        end else if (m_valid) begin
            out_pos = m_pos;
            m_idx   = m_pos / DT;
            m_t     = m_pos % DT;
            lit_n   = ((m_bright + 1) * ON) / (1 << BW);
            on_win  = (m_t >= G) && (m_t < G + lit_n);
            e_skip  = on_win && !m_act_mask[m_idx];
            if (on_win && m_act_mask[m_idx]) begin
                e_an = 8'hFF;
                e_an[m_idx] = 1'b0;
                e_seg = seg_tab[m_act_data[4*m_idx +: 4]];
                e_dp  = !m_act_dp[m_idx];
            end else begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_fs = (m_pos == 0);
            if (m_pos == FT - 1 && m_pend_full) begin
                m_act_data = m_pend_data; m_act_mask = m_pend_mask; m_act_dp = m_pend_dp;
                m_pend_full = 0;
            end else if (wr_valid && !m_pend_full) begin
                m_pend_data = wr_data; m_pend_mask = wr_mask; m_pend_dp = wr_dp;
                m_pend_full = 1;
            end
            if (m_pos == FT - 1) m_bright = int'(brightness);
            m_pos = (m_pos + 1) % FT;
        end
        e_ready = !m_pend_full;
        #1;
        if (m_valid) begin
            check("an", {24'b0, an}, {24'b0, e_an});
            check("wr_ready", {31'b0, wr_ready}, {31'b0, e_ready});
            check("frame_start", {31'b0, frame_start}, {31'b0, e_fs});
            check("one_anode", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (!e_skip) begin
                check("seg", {25'b0, seg}, {25'b0, e_seg});
                check("dp", {31'b0, dp}, {31'b0, e_dp});
            end
        end
    end

    task automatic wait_pos(input int p);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (out_pos == p) return;
        end
        check("wait_pos_timeout", 32'd0, 32'd1);
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
        bit done;
        done = 0;
        wr_data = d; wr_mask = m; wr_dp = p; wr_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            done = wr_ready;
            @(posedge clk); #2;
        end
        wr_valid = 1'b0;
        if (!done) check("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic offer_show(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
        offer(d, m, p);
        for (int i = 0; i < 200 && !wr_ready; i++) begin
            @(posedge clk); #2;
        end
    endtask

    // counts cycles of one whole frame meeting a condition: 0 an==FD, 1 an[0] low, 2 an[1] low, 3 dp low
    task automatic count_frame(input int which, output int n);
        n = 0;
        wait_pos(0);
        for (int i = 0; i < FT; i++) begin
            case (which)
                0: if (an == 8'hFD) n++;
                1: if (!an[0]) n++;
                2: if (!an[1]) n++;
                default: if (!dp) n++;
            endcase
            @(posedge clk); #2;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0; wr_valid = 1'b0; wr_data = 0; wr_mask = 8'hFF; wr_dp = 0; brightness = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        check("rst_an", {24'b0, an}, 32'hFF);
        check("rst_seg", {25'b0, seg}, 32'h7F);
        check("rst_dp", {31'b0, dp}, 32'd1);
        check("rst_fs", {31'b0, frame_start}, 32'd0);
        check("rst_ready", {31'b0, wr_ready}, 32'd1);
        rstn = 1'b1;
        @(posedge clk); #2;
        check("first_pulse", {31'b0, frame_start}, 32'd1);
        for (int i = 1; i <= FT; i++) begin
            @(posedge clk); #2;
            if (i == FT - 1) check("no_pulse_79", {31'b0, frame_start}, 32'd0);
            if (i == FT)     check("pulse_80", {31'b0, frame_start}, 32'd1);
        end
        wait_pos(2);
        check("slot0_an", {24'b0, an}, 32'hFE);
        check("slot0_seg", {25'b0, seg}, 32'b1000000);

        // mid-frame write, shown from the next frame
        wait_pos(30);
        offer(32'h0123ABCF, 8'hFF, 8'h00);
        check("ready_drop", {31'b0, wr_ready}, 32'd0);
        wait_pos(72);
        check("old_frame_d7", {25'b0, seg}, 32'b1000000);
        wait_pos(78);
        check("ready_pre_bnd", {31'b0, wr_ready}, 32'd0);
        @(posedge clk); #2;
        check("ready_post_bnd", {31'b0, wr_ready}, 32'd1);
        wait_pos(2);
        check("new_d0_F", {25'b0, seg}, 32'b0001110);
        wait_pos(72);
        check("new_d7_0", {25'b0, seg}, 32'b1000000);

        // brightness levels
        wait_pos(40); brightness = 4'd3;
        count_frame(0, n); check("bright3_lit", n, 32'd2);
        wait_pos(40); brightness = 4'd0;
        count_frame(0, n); check("bright0_lit", n, 32'd0);
        wait_pos(40); brightness = 4'd15;
        count_frame(0, n); check("bright15_lit", n, 32'd8);

        // digit mask and decimal point
        offer_show(32'h76543210, 8'hAA, 8'h01);
        count_frame(1, n); check("masked_d0", n, 32'd0);
        count_frame(2, n); check("unmasked_d1", n, 32'd8);
        offer_show(32'h76543210, 8'hFF, 8'h01);
        count_frame(3, n); check("dp_d0", n, 32'd8);

        // back-to-back frames with wr_valid held
        wait_pos(20);
        offer(32'h11111115, 8'hFF, 8'h00);
        offer(32'h22222229, 8'hFF, 8'h00);
        wait_pos(2);
        check("frameA_d0", {25'b0, seg}, 32'b0010010);
        wait_pos(2);
        check("frameB_d0", {25'b0, seg}, 32'b0010000);

        // reset mid-LIT of digit 5 drops the pending frame
        wait_pos(10);
        offer(32'h00000007, 8'hFF, 8'h00);
        wait_pos(52);
        check("pre_rst_an", {24'b0, an}, 32'hDF);
        rstn = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_an", {24'b0, an}, 32'hFF);
        check("mid_rst_seg", {25'b0, seg}, 32'h7F);
        check("mid_rst_ready", {31'b0, wr_ready}, 32'd1);
        rstn = 1'b1;
        wait_pos(2);
        check("post_rst_an", {24'b0, an}, 32'hFE);
        check("post_rst_seg", {25'b0, seg}, 32'b1000000);
        wait_pos(2);
        check("pend_lost_seg", {25'b0, seg}, 32'b1000000);

        // randomized traffic against the model
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 90)) begin
                @(posedge clk); #2;
                if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
            end
            offer($urandom, 8'($urandom), 8'($urandom));
        end
        repeat (200) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
- Time-multiplexed scan controller for the Nexys 8-digit common-anode seven-segment display.
- Sequences the anodes and inserts a blanking guard between digits to stop ghosting.
- Applies frame-level PWM brightness and a per-digit enable mask.
- Double-buffers digit values behind a valid/ready handshake, so producers such as the hex up-counter never cause a torn frame.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..8).
- CLK_HZ, 100_000_000, input clock frequency.
- REFRESH_HZ, 1000, full-frame refresh rate.
- GUARD_TICKS, 500, blank clocks at the start of each digit slot. Must be < DIGIT_TICKS.
- BRIGHT_W, 4, brightness code width.
- Derived: DIGIT_TICKS = CLK_HZ/(REFRESH_HZ*N_DIGITS); ON_TICKS = DIGIT_TICKS-GUARD_TICKS.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- wr_valid  in  1  producer offers a new frame.
- wr_ready  out  1  pending buffer is empty.
- wr_data  in  4*N_DIGITS  hex nibbles; digit i = wr_data[4i+3:4i].
- wr_mask  in  N_DIGITS  1 = digit enabled.
- wr_dp  in  N_DIGITS  1 = decimal point lit.
- brightness  in  BRIGHT_W  PWM level, sampled at frame start.
- an  out  N_DIGITS  anode enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (rstn low at a clk edge):
  - an = all 1s, seg = 7'h7F, dp = 1, frame_start = 0, wr_ready = 1.
  - Digit index 0, slot tick 0.
  - Active buffer: data 0, mask all 1s, dp 0; pending buffer empty.
  - Latched brightness = all 1s.
  - Mid-frame reset aborts the scan immediately; a pending frame is discarded.
- Slot counter t runs 0..DIGIT_TICKS-1 per digit. Digit index runs 0..N_DIGITS-1 and wraps to 0 at the end of the last slot.
- Phases within a slot:
  - GUARD: t < GUARD_TICKS. All anodes off, seg = 7'h7F, dp = 1.
  - LIT: GUARD_TICKS <= t < GUARD_TICKS+lit_ticks. an[index] = 0, seg = decode(nibble), dp = ~dp_bit.
  - DARK: remainder of the slot, same outputs as GUARD.
- lit_ticks = ((brightness_latched+1)*ON_TICKS) >> BRIGHT_W.
  - Integer arithmetic, intermediate width clog2(ON_TICKS)+BRIGHT_W+1.
  - Max code gives ON_TICKS (full on). Result 0 keeps the digit dark the whole slot.
- A masked digit (mask bit 0) keeps its anode high for the whole slot. Timing is unchanged; the slot is not skipped.
- Outputs are registered and lag the internal (index, t) state by exactly 1 clk. At most one anode is low in any cycle.
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Handshake:
  - A transfer occurs on a clk edge with wr_valid & wr_ready. {wr_data, wr_mask, wr_dp} go into the pending buffer, and wr_ready drops the next cycle.
  - Producer must hold its data stable only while wr_valid & !wr_ready.
- Frame boundary: the edge where the state moves (index N_DIGITS-1, t=DIGIT_TICKS-1) -> (0,0).
  - If pending is full, it is copied to the active buffer and wr_ready returns to 1 the next cycle.
  - brightness is latched on the same edge.
  - Internal frame flag goes high; frame_start pulses on the following cycle, aligned with the registered outputs. The first frame after reset also pulses.
- Simultaneous write and swap on the same boundary edge: the old pending contents go active. New data is accepted only if wr_ready was 1 that cycle, and it lands in pending for the next frame. No data loss, no duplication.
- Active data never changes mid-frame.

Test Plan (sim params CLK_HZ=800, REFRESH_HZ=10, N_DIGITS=8, GUARD_TICKS=2 -> DIGIT_TICKS=10, ON_TICKS=8):
- Reset released, no writes:
  - frame_start pulses at cycle 1 and then every 80 clks.
  - Each digit slot shows 2 blank clks, then an[i]=0 with seg=1000000 for 8 clks.
  - Never more than one anode low.
- Write data=32'h0123ABCF, mask=8'hFF mid-frame:
  - wr_ready drops 1 clk after acceptance.
  - Current frame still shows 0s.
  - Next frame: digit0 seg=0001110 (F), digit7 seg=1000000 (0).
  - wr_ready high again 1 clk after the boundary.
- brightness=3 written before a boundary: each digit is lit for 2 clks per slot. brightness=0 -> never lit. brightness=15 -> lit 8 clks.
- mask=8'b1010_1010, dp=8'h01: digits 0,2,4,6 never light; their slots still take 10 clks. dp=0 only during digit0's lit clks — and since digit0 is masked here, it never shows; repeat with mask=8'hFF to confirm.
- Hold wr_valid continuously with frames A then B, B offered on the boundary cycle: A shows the first full frame, B the following frame, no torn frame.
- Assert rstn=0 for 1 clk mid-LIT of digit 5: the next cycle an=FF and seg=7F; the scan restarts at digit0 and the pending frame is lost.
